// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Request/response bundle between two requesters and the ALU arbiter.
//   req0_*/req1_*   : operation request (valid, ready, op, a, b)
//   resp0_*/resp1_* : captured result back to each requester
//                     (valid, ready, result, flags)
// Modports:
//   master : requester side (drives requests, consumes responses)
//   slave  : arbiter side (accepts requests, produces responses)
interface alu_arbiter_if #(
    parameter int W = 16
);
    logic         req0_valid;
    logic         req0_ready;
    logic [4:0]   req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;

    logic         req1_valid;
    logic         req1_ready;
    logic [4:0]   req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;

    logic         resp0_valid;
    logic         resp0_ready;
    logic [W-1:0] resp0_result;
    logic [3:0]   resp0_flags;

    logic         resp1_valid;
    logic         resp1_ready;
    logic [W-1:0] resp1_result;
    logic [3:0]   resp1_flags;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp0_ready, resp1_ready,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_result, resp0_flags,
        input  resp1_valid, resp1_result, resp1_flags
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp0_ready, resp1_ready,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_result, resp0_flags,
        output resp1_valid, resp1_result, resp1_flags
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external combinational ALU between two requesters.
// Each accepted operation goes IDLE -> ISSUE -> RESP -> IDLE, so at most
// one operation is in flight and throughput is one op per three cycles.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   bus (slave)          : request/response bundle, see alu_arbiter_if
//   alu_op, alu_a, alu_b : operands presented to the shared ALU
//   alu_result, alu_flags: ALU outputs, captured at the end of ISSUE
//   busy                 : high whenever the FSM is not IDLE
//   dbg_state            : current FSM state (IDLE=0, ISSUE=1, RESP=2)
//
// Handshake: a transfer happens at a rising edge where valid and ready
// are both high. reqN_ready is only ever high in IDLE, for the single
// granted valid requester. respN_valid stays high with stable
// result/flags until respN_ready is sampled high; respN_ready seen while
// respN_valid is low is ignored.
//
// Configuration macro ALU_ARB_RR_EN:
//   defined   : round-robin, the requester not granted last wins a tie;
//               the priority pointer moves only on a request handshake.
//   undefined : fixed priority, requester 0 always wins a tie.
module alu_arbiter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus,
    output logic [4:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic         busy,
    output logic [1:0]   dbg_state
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic         gnt_id;
    logic [4:0]   op_r;
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;
    logic [W-1:0] result_r;
    logic [3:0]   flags_r;

    logic pick;   // requester that would be granted if IDLE (0 or 1)
    logic hs0;
    logic hs1;
    logic hs;
    logic resp_take;

`ifdef ALU_ARB_RR_EN
    // prio names the requester that wins a tie; it points away from the
    // requester granted most recently.
    logic prio;

    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            pick = prio;
        end else begin
            pick = bus.req1_valid && !bus.req0_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (hs) begin
            prio <= hs0;
        end
    end
`else
    // Requester 1 is only chosen when requester 0 is not asking.
    assign pick = !bus.req0_valid;
`endif

    assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !pick;
    assign bus.req1_ready = (state == IDLE) && bus.req1_valid && pick;

    assign hs0 = bus.req0_valid && bus.req0_ready;
    assign hs1 = bus.req1_valid && bus.req1_ready;
    assign hs  = hs0 || hs1;

    assign bus.resp0_valid  = (state == RESP) && !gnt_id;
    assign bus.resp1_valid  = (state == RESP) && gnt_id;
    assign bus.resp0_result = result_r;
    assign bus.resp1_result = result_r;
    assign bus.resp0_flags  = flags_r;
    assign bus.resp1_flags  = flags_r;

    assign resp_take = (bus.resp0_valid && bus.resp0_ready) ||
                       (bus.resp1_valid && bus.resp1_ready);

    // The ALU always sees the last accepted operands, so its inputs only
    // move on a request handshake.
    assign alu_op = op_r;
    assign alu_a  = a_r;
    assign alu_b  = b_r;

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    if (resp_take) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_id   <= 1'b0;
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            flags_r  <= '0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                gnt_id <= hs1;
                op_r   <= hs1 ? bus.req1_op : bus.req0_op;
                a_r    <= hs1 ? bus.req1_a  : bus.req0_a;
                b_r    <= hs1 ? bus.req1_b  : bus.req0_b;
            end
            if (state == ISSUE) begin
                result_r <= alu_result;
                flags_r  <= alu_flags;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Bench for alu_arbiter: reset values, single operation latency,
// contention under the compiled arbitration policy, response backpressure,
// reset in the middle of an operation and a randomized run checked
// against a transaction-level reference model.
module tb_alu_arbiter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [4:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic         busy;
    logic [1:0]   dbg_state;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    logic [3:0]   exp_fq[$];
    int           exp_pq[$];

    alu_arbiter_if #(.W(W)) bus ();

    alu_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- ALU behaviour (also the reference for results) ----
    function automatic logic [W-1:0] ref_result(input logic [4:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            5'd0:    r = a + b;
            5'd1:    r = a - b;
            5'd2:    r = $signed(a) >>> b[3:0];
            5'd3:    r = a & b;
            5'd4:    r = a | b;
            5'd5:    r = a ^ b;
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] ref_flags(input logic [4:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        r = ref_result(op, a, b);
        return {r[W-1], (r == '0), ^r, op[0]};
    endfunction

    always_comb begin
        alu_result = ref_result(alu_op, alu_a, alu_b);
        alu_flags  = ref_flags(alu_op, alu_a, alu_b);
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input int port, input logic v, input logic [4:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        if (port == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic idle_inputs();
        drive_req(0, 1'b0, 5'd0, '0, '0);
        drive_req(1, 1'b0, 5'd0, '0, '0);
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
    endtask

    // Returns at posedge+1 with reset released and all inputs idle.
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (bus.resp0_valid !== 1'b0 || bus.resp1_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b%b want 00", bus.resp1_valid, bus.resp0_valid); end
        checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b%b want 00", bus.req1_ready, bus.req0_ready); end
        checks++; if (alu_op !== 5'd0 || alu_a !== '0 || alu_b !== '0) begin errors++; $display("FAIL reset_alu: got op=%0h a=%0h b=%0h want 0", alu_op, alu_a, alu_b); end
        checks++; if (bus.resp0_result !== '0 || bus.resp1_flags !== 4'd0) begin errors++; $display("FAIL reset_result: got %0h/%0h want 0/0", bus.resp0_result, bus.resp1_flags); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        // First request after release is accepted immediately.
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_req(1, 1'b1, 5'd3, 16'hF0F0, 16'h0FF0);
        bus.resp1_ready = 1'b1;
        #1;
        checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin errors++; $display("FAIL first_accept: got r1=%b r0=%b want 1 0", bus.req1_ready, bus.req0_ready); end
        @(posedge clk); #1;
        drive_req(1, 1'b0, 5'd0, '0, '0);
        #1;
        checks++; if (busy !== 1'b1 || bus.resp1_valid !== 1'b0) begin errors++; $display("FAIL first_issue: got busy=%b v=%b want 1 0", busy, bus.resp1_valid); end
        @(posedge clk); #2;
        checks++; if (bus.resp1_valid !== 1'b1 || bus.resp1_result !== 16'h00F0) begin errors++; $display("FAIL first_resp: got v=%b res=%0h want 1 f0", bus.resp1_valid, bus.resp1_result); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_single_op();
        do_reset();
        drive_req(0, 1'b1, 5'b00010, 16'd16, 16'd4);
        bus.resp0_ready = 1'b1;
        #1;
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL single_grant: got r0=%b r1=%b want 1 0", bus.req0_ready, bus.req1_ready); end
        @(posedge clk); #1;                      // handshake edge
        drive_req(0, 1'b0, 5'd0, '0, '0);
        #1;
        checks++; if (busy !== 1'b1 || bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL single_issue: got busy=%b v=%b want 1 0", busy, bus.resp0_valid); end
        checks++; if (alu_op !== 5'b00010 || alu_a !== 16'd16 || alu_b !== 16'd4) begin errors++; $display("FAIL single_alu_in: got %0h %0d %0d want 2 16 4", alu_op, alu_a, alu_b); end
        checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL single_issue_ready: got %b%b want 00", bus.req1_ready, bus.req0_ready); end
        @(posedge clk); #2;                      // second edge after handshake
        checks++; if (bus.resp0_valid !== 1'b1 || bus.resp1_valid !== 1'b0) begin errors++; $display("FAIL single_latency: got v0=%b v1=%b want 1 0", bus.resp0_valid, bus.resp1_valid); end
        checks++; if (bus.resp0_result !== 16'd1 || bus.resp0_flags !== ref_flags(5'd2, 16'd16, 16'd4)) begin errors++; $display("FAIL single_result: got %0d/%0h want 1/%0h", bus.resp0_result, bus.resp0_flags, ref_flags(5'd2, 16'd16, 16'd4)); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_resp: got %b want 1", busy); end
        @(posedge clk); #2;
        checks++; if (busy !== 1'b0 || bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL single_done: got busy=%b v=%b want 0 0", busy, bus.resp0_valid); end
        checks++; if (alu_a !== 16'd16 || alu_b !== 16'd4) begin errors++; $display("FAIL single_alu_hold: got %0d %0d want 16 4", alu_a, alu_b); end
        idle_inputs();
    endtask

    task automatic test_contention();
        int g;
        int want;
        do_reset();
        drive_req(0, 1'b1, 5'b00010, 16'd9, 16'd1);
        drive_req(1, 1'b1, 5'b00010, 16'd16, 16'd4);
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g = -1;
            for (int c = 0; c < 6; c++) begin
                #1;
                checks++; if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) begin errors++; $display("FAIL cont_double_grant: got 11 want one-hot"); end
`ifndef ALU_ARB_RR_EN
                checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL cont_fixed_r1: got %b want 0", bus.req1_ready); end
`endif
                if (bus.req0_ready === 1'b1) g = 0;
                else if (bus.req1_ready === 1'b1) g = 1;
                @(posedge clk); #1;
                if (g >= 0) break;
            end
            checks++;
            if (g < 0) begin
                errors++; $display("FAIL cont_timeout: got no grant want grant %0d", k);
                break;
            end
`ifdef ALU_ARB_RR_EN
            want = k % 2;
`else
            want = 0;
`endif
            if (g != want) begin errors++; $display("FAIL cont_grant_order: got %0d want %0d at op %0d", g, want, k); end
            #1;
            checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin errors++; $display("FAIL cont_issue_ready: got %b%b want 00", bus.req1_ready, bus.req0_ready); end
            @(posedge clk); #2;
            if (g == 0) begin
                checks++; if (bus.resp0_valid !== 1'b1 || bus.resp1_valid !== 1'b0 || bus.resp0_result !== 16'd4) begin errors++; $display("FAIL cont_resp0: got v=%b%b res=%0d want 01 4", bus.resp1_valid, bus.resp0_valid, bus.resp0_result); end
            end else begin
                checks++; if (bus.resp1_valid !== 1'b1 || bus.resp0_valid !== 1'b0 || bus.resp1_result !== 16'd1) begin errors++; $display("FAIL cont_resp1: got v=%b%b res=%0d want 10 1", bus.resp1_valid, bus.resp0_valid, bus.resp1_result); end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [3:0] ef;
        do_reset();
        drive_req(1, 1'b1, 5'd0, 16'd100, 16'd23);
        bus.resp1_ready = 1'b0;
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL bp_grant: got %b want 1", bus.req1_ready); end
        @(posedge clk); #1;
        drive_req(1, 1'b0, 5'd0, '0, '0);
        drive_req(0, 1'b1, 5'd5, 16'h1234, 16'h00FF);
        bus.resp0_ready = 1'b1;
        ef = ref_flags(5'd0, 16'd100, 16'd23);
        @(posedge clk); #2;
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.resp1_valid !== 1'b1 || bus.resp1_result !== 16'd123 || bus.resp1_flags !== ef) begin errors++; $display("FAIL bp_hold: cycle %0d got v=%b res=%0d fl=%0h want 1 123 %0h", c, bus.resp1_valid, bus.resp1_result, bus.resp1_flags, ef); end
            checks++; if (bus.req0_ready !== 1'b0 || bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL bp_req0_blocked: cycle %0d got rdy=%b v0=%b want 0 0", c, bus.req0_ready, bus.resp0_valid); end
            @(posedge clk); #2;
        end
        bus.resp1_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp1_ready = 1'b0;
        #1;
        checks++; if (dbg_state !== 2'd0 || busy !== 1'b0 || bus.resp1_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got st=%0d busy=%b v1=%b want 0 0 0", dbg_state, busy, bus.resp1_valid); end
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL bp_next_grant: got %b want 1", bus.req0_ready); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        drive_req(0, 1'b1, 5'd1, 16'd50, 16'd8);
        bus.resp0_ready = 1'b1;
        @(posedge clk); #1;
        drive_req(0, 1'b0, 5'd0, '0, '0);
        #1;
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL mid_in_issue: got %0d want 1", dbg_state); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || dbg_state !== 2'd0 || bus.resp0_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got busy=%b st=%0d v=%b want 0 0 0", busy, dbg_state, bus.resp0_valid); end
        checks++; if (alu_op !== 5'd0 || alu_a !== '0 || alu_b !== '0 || bus.resp0_result !== '0) begin errors++; $display("FAIL mid_reset_values: got %0h %0h %0h %0h want 0", alu_op, alu_a, alu_b, bus.resp0_result); end
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (bus.resp0_valid !== 1'b0 || bus.resp1_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_no_resp: cycle %0d got v=%b%b busy=%b want 00 0", c, bus.resp1_valid, bus.resp0_valid, busy); end
            @(posedge clk); #1;
        end
        drive_req(0, 1'b1, 5'd1, 16'd50, 16'd8);
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL mid_next_grant: got %b want 1", bus.req0_ready); end
        @(posedge clk); #1;
        drive_req(0, 1'b0, 5'd0, '0, '0);
        @(posedge clk); #2;
        checks++; if (bus.resp0_valid !== 1'b1 || bus.resp0_result !== 16'd42) begin errors++; $display("FAIL mid_next_result: got v=%b res=%0d want 1 42", bus.resp0_valid, bus.resp0_result); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Randomized traffic against a transaction-level model: an operation
    // is outstanding from its handshake until its response is consumed,
    // the response is visible from the second edge after the handshake,
    // and the ALU always shows the operands of the last accepted request.
    task automatic test_random();
        int           m_busy;
        int           m_port;
        int           m_age;
        int           m_prio;
        logic [4:0]   m_op;
        logic [W-1:0] m_a;
        logic [W-1:0] m_b;
        logic         v0, v1, rr0, rr1;
        logic [4:0]   op0, op1;
        logic [W-1:0] a0, b0, a1, b1;
        int           win;
        logic         e_r0, e_r1, e_v0, e_v1, take;
        int           done0, done1;
        do_reset();
        exp_q.delete(); exp_fq.delete(); exp_pq.delete();
        m_busy = 0; m_port = 0; m_age = 0; m_prio = 0;
        m_op = '0; m_a = '0; m_b = '0;
        done0 = 0; done1 = 0;
        for (int cyc = 0; cyc < 460; cyc++) begin
            // The last cycles only drain what is outstanding.
            v0 = (cyc < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
            v1 = (cyc < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
            op0 = 5'($urandom_range(0, 7)); a0 = W'($urandom); b0 = W'($urandom);
            op1 = 5'($urandom_range(0, 7)); a1 = W'($urandom); b1 = W'($urandom);
            rr0 = (cyc < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
            rr1 = (cyc < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
            drive_req(0, v0, op0, a0, b0);
            drive_req(1, v1, op1, a1, b1);
            bus.resp0_ready = rr0;
            bus.resp1_ready = rr1;
            #1;
            if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
                win = m_prio;
`else
                win = 0;
`endif
            end else begin
                win = (v1 && !v0) ? 1 : 0;
            end
            e_r0 = (m_busy == 0) && v0 && (win == 0);
            e_r1 = (m_busy == 0) && v1 && (win == 1);
            e_v0 = (m_busy == 1) && (m_age >= 2) && (m_port == 0);
            e_v1 = (m_busy == 1) && (m_age >= 2) && (m_port == 1);
            checks++; if (bus.req0_ready !== e_r0 || bus.req1_ready !== e_r1) begin errors++; $display("FAIL rnd_ready: cyc %0d got %b%b want %b%b", cyc, bus.req1_ready, bus.req0_ready, e_r1, e_r0); end
            checks++; if (bus.resp0_valid !== e_v0 || bus.resp1_valid !== e_v1) begin errors++; $display("FAIL rnd_resp_valid: cyc %0d got %b%b want %b%b", cyc, bus.resp1_valid, bus.resp0_valid, e_v1, e_v0); end
            checks++; if (busy !== (m_busy == 1)) begin errors++; $display("FAIL rnd_busy: cyc %0d got %b want %0d", cyc, busy, m_busy); end
            checks++; if (alu_op !== m_op || alu_a !== m_a || alu_b !== m_b) begin errors++; $display("FAIL rnd_alu_in: cyc %0d got %0h %0h %0h want %0h %0h %0h", cyc, alu_op, alu_a, alu_b, m_op, m_a, m_b); end
            if ((e_v0 || e_v1) && exp_q.size() > 0) begin
                if (e_v0) begin
                    checks++; if (bus.resp0_result !== exp_q[0] || bus.resp0_flags !== exp_fq[0]) begin errors++; $display("FAIL rnd_result0: cyc %0d got %0h/%0h want %0h/%0h", cyc, bus.resp0_result, bus.resp0_flags, exp_q[0], exp_fq[0]); end
                end else begin
                    checks++; if (bus.resp1_result !== exp_q[0] || bus.resp1_flags !== exp_fq[0]) begin errors++; $display("FAIL rnd_result1: cyc %0d got %0h/%0h want %0h/%0h", cyc, bus.resp1_result, bus.resp1_flags, exp_q[0], exp_fq[0]); end
                end
            end
            take = (e_v0 && rr0) || (e_v1 && rr1);
            @(posedge clk); #1;
            if (take) begin
                if (exp_pq[0] == 0) done0++; else done1++;
                void'(exp_q.pop_front()); void'(exp_fq.pop_front()); void'(exp_pq.pop_front());
                m_busy = 0;
            end else if (m_busy == 1) begin
                m_age++;
            end
            if (e_r0 || e_r1) begin
                m_port = e_r1 ? 1 : 0;
                m_op   = e_r1 ? op1 : op0;
                m_a    = e_r1 ? a1 : a0;
                m_b    = e_r1 ? b1 : b0;
                m_busy = 1;
                m_age  = 1;
                m_prio = 1 - m_port;
                exp_q.push_back(ref_result(m_op, m_a, m_b));
                exp_fq.push_back(ref_flags(m_op, m_a, m_b));
                exp_pq.push_back(m_port);
            end
        end
        checks++; if (exp_q.size() != 0 || m_busy != 0) begin errors++; $display("FAIL rnd_drain: got %0d outstanding want 0", exp_q.size()); end
        checks++; if (done0 == 0 || done1 == 0) begin errors++; $display("FAIL rnd_coverage: got done0=%0d done1=%0d want both >0", done0, done1); end
        idle_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter W, default 16, SHALL set operand/result width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 reqN_valid  input  1  (N=0,1) SHALL flag a pending operation from requester N.
REQ-005 reqN_ready  output  1  SHALL flag that requester N's operation is accepted this cycle.
REQ-006 reqN_op  input  5  SHALL carry the ALU opcode from requester N.
REQ-007 reqN_a, reqN_b  input  W  SHALL carry the signed operands from requester N.
REQ-008 respN_valid  output  1  SHALL flag a valid response to requester N.
REQ-009 respN_ready  input  1  SHALL flag that requester N consumes its response.
REQ-010 respN_result  output  W  SHALL carry the captured ALU result.
REQ-011 respN_flags  output  4  SHALL carry the captured ALU flags.
REQ-012 alu_op  output  5; alu_a, alu_b  output  W  SHALL drive the shared combinational ALU.
REQ-013 alu_result  input  W; alu_flags  input  4  SHALL return the ALU outputs.
REQ-014 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, RESP.
REQ-016 In IDLE, a grant SHALL be made to at most one valid requester; the granted reqN_ready SHALL be high combinationally in that cycle, the other low.
REQ-017 On handshake (valid&ready at an edge), op/a/b and the grant id SHALL be registered and the state SHALL go to ISSUE.
REQ-018 In ISSUE, alu_op/alu_a/alu_b SHALL present the registered values; at the next edge alu_result/alu_flags SHALL be captured and the state SHALL go to RESP.
REQ-019 In RESP, respN_valid SHALL be high only for the granted requester, with stable result/flags, until respN_ready is sampled high; then the state SHALL return to IDLE.
REQ-020 Latency: respN_valid SHALL rise exactly 2 edges after the request handshake edge.
REQ-021 Both reqN_ready SHALL be low in ISSUE and RESP; no new request is accepted until return to IDLE (throughput max 1 op per 3 cycles).
REQ-022 In IDLE and RESP, alu_op/alu_a/alu_b SHALL hold the last registered values (no spurious toggling).
REQ-023 Requester inputs changing while not ready SHALL have no effect.
REQ-024 respN_ready asserted while respN_valid is low SHALL be ignored.

Reset
REQ-025 On rst_n low, state SHALL be IDLE immediately, regardless of the state in progress; any in-flight operation SHALL be discarded without a response.
REQ-026 Reset values: all reqN_ready/respN_valid 0, busy 0, respN_result 0, respN_flags 0, alu_op/alu_a/alu_b 0, priority pointer to requester 0.
REQ-027 After rst_n rises, the first request SHALL be accepted in the first cycle with valid high.

Configuration
REQ-028 Macro ALU_ARB_RR_EN SHALL select arbitration policy.
REQ-029 With ALU_ARB_RR_EN defined: round-robin; on simultaneous valid, the requester not granted last SHALL win; the pointer SHALL update only on handshake.
REQ-030 Without ALU_ARB_RR_EN: fixed priority; requester 0 SHALL always win on simultaneous valid; no pointer register.

Verification
REQ-031 Single op: req0 op=5'b00010, a=16, b=4, resp0_ready=1 -> resp0_valid 2 edges after handshake, resp0_result=1, busy high for 2 cycles.
REQ-032 Contention (RR_EN): both valid continuously, req0 a=9,b=1 op=5'b00010; req1 a=16,b=4 same op -> grants alternate 0,1,0,1; results 4 and 1 routed to the correct port.
REQ-033 Contention (no RR_EN): same stimulus -> req0 granted every time, req1_ready never high while req0_valid high.
REQ-034 Backpressure: resp1_ready held low 5 cycles -> resp1_valid, result, flags stable all 5 cycles, req0_ready low throughout, IDLE one edge after resp1_ready=1.
REQ-035 Reset mid-op: rst_n low during ISSUE -> all outputs at reset values immediately, no respN_valid after release; next request completes with correct result.
